// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv.sv
// Programmable registered clock divider with ratio reload, stop/start and period tick.
// Optional GF180MCU_OSU_CLKDIV_DUTY50_EN adds a negedge flop for 50% duty on odd ratios.
module gf180mcu_osu_sc_gp12t3v3__clkdiv #(
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [DIV_W-1:0] DIV,
    input  logic             LD,
    output logic             ACK,
    output logic             BUSY,
    output logic             TICK,
    output logic             Y
);

    localparam logic [DIV_W-1:0] RST_RATIO = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO       = DIV_W'(2);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] ratio;
    logic [DIV_W-1:0] pend;
    logic [DIV_W-1:0] div_c;
    logic [DIV_W-1:0] nxt_ratio;
    logic [DIV_W-1:0] nxt_cnt;
    logic [DIV_W-1:0] half;
    logic             run;
    logic             run_n;
    logic             yp;
    logic             wrap;
    logic             apply;

    always_comb begin
        div_c     = (DIV < TWO) ? TWO : DIV;
        wrap      = run && (cnt == ratio - ONE);
        // a pending ratio lands on a boundary, or right away while parked
        apply     = BUSY && (wrap || !run);
        nxt_ratio = apply ? pend : ratio;
        half      = nxt_ratio >> 1;
        nxt_cnt   = (wrap || !run) ? '0 : cnt + ONE;
        run_n     = run ? (wrap ? EN : 1'b1) : EN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt   <= '0;
            ratio <= RST_RATIO;
            pend  <= RST_RATIO;
            BUSY  <= 1'b0;
            run   <= 1'b0;
            yp    <= 1'b0;
            TICK  <= 1'b0;
            ACK   <= 1'b0;
        end else begin
            ratio <= nxt_ratio;
            ACK   <= apply;
            if (LD) begin
                pend <= div_c;
                BUSY <= 1'b1;
            end else if (apply) begin
                BUSY <= 1'b0;
            end
            run  <= run_n;
            cnt  <= run_n ? nxt_cnt : '0;
            yp   <= run_n && (nxt_cnt < half);
            TICK <= run_n && (wrap || !run);
        end
    end

`ifdef GF180MCU_OSU_CLKDIV_DUTY50_EN
    logic yn;

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) yn <= 1'b0;
        else     yn <= yp;
    end

    assign Y = yp | (yn & ratio[0]);
`else
    assign Y = yp;
`endif

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__clkdiv.sv
// Scoreboard bench for the clock divider: stimulus pushes expected
// {Y,TICK,ACK,BUSY} per cycle, a negedge monitor pops and compares.
module tb_gf180mcu_osu_sc_gp12t3v3__clkdiv;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic [7:0] DIV;
    logic       LD;
    logic       ACK;
    logic       BUSY;
    logic       TICK;
    logic       Y;

    int checks;
    int errors;
    int vec_id;

    logic [3:0] expq[$];
    int         idq[$];
    logic [3:0] e;
    logic [3:0] got;
    int         id;

    gf180mcu_osu_sc_gp12t3v3__clkdiv #(
        .DIV_W  (8),
        .DIV_RST(2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .EN  (EN),
        .DIV (DIV),
        .LD  (LD),
        .ACK (ACK),
        .BUSY(BUSY),
        .TICK(TICK),
        .Y   (Y)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (expq.size() > 0) begin
            e   = expq.pop_front();
            id  = idq.pop_front();
            got = {Y, TICK, ACK, BUSY};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL vec%0d {Y,TICK,ACK,BUSY} got %b expected %b",
                         id, got, e);
            end
        end
    end

    task automatic push(input logic [3:0] v);
        expq.push_back(v);
        idq.push_back(vec_id);
        vec_id++;
    endtask

    task automatic cyc(input bit en, input bit ld, input logic [7:0] d,
                       input bit y, input bit t, input bit a, input bit b);
        EN  = en;
        LD  = ld;
        DIV = d;
        @(posedge CLK);
        #1;
        push({y, t, a, b});
    endtask

    // One running period of ratio n; optional loads at cycle indices l1/l2.
    task automatic per(input int n, input bit a, input int l1, input int d1,
                       input int l2, input int d2);
        bit ld;
        bit b;
        int d;
        for (int c = 0; c < n; c++) begin
            ld = (c == l1) || (c == l2);
            d  = (c == l2) ? d2 : d1;
            b  = (l1 >= 0 && c >= l1) || (l2 >= 0 && c >= l2);
            cyc(1'b1, ld, 8'(d), c < n / 2, c == 0, a && c == 0, b);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vec_id = 0;
        RST = 1'b1;
        EN  = 1'b0;
        LD  = 1'b0;
        DIV = 8'd0;
        @(posedge CLK);
        #1;
        push(4'b0000);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        per(2, 0, -1, 0, -1, 0);
        per(2, 0, -1, 0, -1, 0);
        per(2, 0, 1, 6, -1, 0);
        per(6, 1, -1, 0, -1, 0);
        per(6, 0, 2, 5, -1, 0);
        per(5, 1, -1, 0, -1, 0);
        per(5, 0, 1, 4, 3, 7);
        per(7, 1, -1, 0, -1, 0);
        per(7, 0, 1, 0, -1, 0);
        per(2, 1, -1, 0, -1, 0);
        per(2, 0, 1, 1, -1, 0);
        per(2, 1, 1, 8, -1, 0);
        per(8, 1, -1, 0, -1, 0);

        for (int c = 0; c < 8; c++)
            cyc(c < 2, 1'b0, 8'd0, c < 4, c == 0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        per(8, 0, -1, 0, -1, 0);

        for (int c = 0; c < 8; c++)
            cyc(c == 0, 1'b0, 8'd0, c < 4, c == 0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        per(9, 0, -1, 0, -1, 0);

        cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        EN = 1'b1;
        LD = 1'b0;
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #2;
        RST = 1'b0;
        push(4'b0000);
        per(2, 0, -1, 0, -1, 0);
        per(2, 0, -1, 0, -1, 0);
        EN = 1'b0;

        repeat (3) @(negedge CLK);
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__clkdiv.md
# gf180mcu_osu_sc_gp12t3v3__clkdiv

Parametrised, programmable clock divider for the gp12t3v3 clock-tree cell set. It extends the fixed clock buffer into a registered divide-by-N source with run-time ratio reload, glitch-free stop/start and a period-start tick. It sits at the root of local clock sub-trees and drives the clkbuf cells downstream. All state is on CLK; output edges come only from flops, never from combinational gating.

## Interface
- DIV_W, 8: width of the ratio field; legal ratios N = 2 .. 2^DIV_W−1.
- DIV_RST, 2: ratio loaded at reset; must be ≥2.
- CLK  input  1  source clock; all flops on posedge (negedge flop only under the macro).
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  run enable; sampled on posedge.
- DIV  input  DIV_W  requested ratio; values 0 and 1 are treated as 2.
- LD  input  1  one-cycle request to load DIV.
- ACK  output  1  one-cycle pulse when a loaded ratio takes effect.
- BUSY  output  1  a loaded ratio is pending.
- TICK  output  1  one-cycle pulse in the first CLK cycle of each output period.
- Y  output  1  divided clock.

## Operation
- State: CNT (DIV_W bits), RATIO (active N), PEND (pending N), BUSY, RUN.
- H = floor(RATIO/2). Y is high for CNT in [0, H), low for CNT in [H, RATIO−1].
- Running: CNT increments each posedge; at CNT = RATIO−1 it wraps to 0 (period boundary).
- Stop: EN=0 is honoured only at a boundary. The counter parks at 0 with RUN=0 and Y=0, and TICK stays 0. A high phase is never truncated.
- Start: with RUN=0 and EN=1, the next posedge sets CNT=0 and RUN=1, Y rises and TICK pulses.
- Load: when LD=1, PEND ← clamp(DIV) and BUSY ← 1.
  - At the next boundary, or the next posedge if RUN=0: RATIO ← PEND, BUSY ← 0, ACK pulses for one cycle, aligned with the first cycle of the new period.
- LD while BUSY: PEND is overwritten, only one ACK is issued, and the last value wins.
- LD in the same cycle as the boundary: the old PEND (if any) is applied, and the new DIV becomes PEND with BUSY staying 1.
- Width rule: the comparison and wrap are done at DIV_W bits; RATIO never wraps because its maximum is 2^DIV_W−1.

## Timing
- Reset values: CNT=0, RATIO=DIV_RST, PEND=DIV_RST, RUN=0, Y=0, TICK=0, ACK=0, BUSY=0.
- Reset mid-period: Y drops asynchronously and any pending load is discarded.
- Y, TICK and ACK are registered outputs: clock-to-Q after the CLK posedge, no combinational path from inputs.
- Start latency: EN rising is sampled at posedge k, and Y rises at posedge k (RUN was 0) with TICK high for cycle k..k+1.
- Ratio-change latency: at most RATIO cycles from the LD sample to ACK.
- Duty cycle:
  - Even N: exactly 50%.
  - Odd N: H high, H+1 low (see Configuration).

## Configuration
- GF180MCU_OSU_CLKDIV_DUTY50_EN defined:
  - Adds one negedge flop YN ← Yp, with output Y = Yp | (YN & RATIO[0]).
  - Odd N becomes high for H+0.5 cycles, giving 50% duty. Even N is unchanged.
  - Reset clears YN as well.
- Macro undefined: Y = Yp, so odd N runs at H/N duty. No negedge flop exists.

## Test plan
- Reset with DIV_RST=2, then EN=1 → Y toggles every posedge (period 2 CLK), TICK pulses every 2nd cycle, ACK=0 and BUSY=0.
- Running at N=2, LD with DIV=6 → BUSY=1 until the next boundary, ACK pulses once, then Y is 3 high / 3 low.
- N=5, macro undefined → Y is 2 high / 3 low. With the macro defined → Y is high for 2.5 CLK and low for 2.5 CLK.
- N=8, EN deasserted at CNT=1 → Y stays high through CNT=3 and falls, then stays 0 and TICK=0. Re-asserting EN gives Y rising on the next posedge together with a TICK.
- Back-to-back LD with DIV=4 then DIV=7 within one period → a single ACK, and the new period is 7 cycles. DIV=0 or DIV=1 → a period of 2.
- RST asserted mid-high-phase with BUSY=1 → Y=0 immediately, BUSY=0, and RATIO returns to DIV_RST after release.
